// File: rtl/updown_counter_repeat.sv
// updown_counter_repeat
//   WIDTH-bit up/down counter driven by debounced, synchronised button levels.
//   Each press gives one step. A held inc/dec button auto-repeats after a
//   hold delay. There is also a free-running run-mode tick, and the
//   arithmetic either wraps or saturates.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   ce       in   clock enable; when low every register holds (rst still acts)
//   buttons  in   [0] inc, [1] dec, [2] run toggle, [3] clear (levels)
//   count    out  current counter value
//   running  out  run mode active
//   limit    out  one-cycle pulse when a step wraps (WRAP=1) or is blocked
//                 at a bound (WRAP=0)
module updown_counter_repeat #(
  parameter int WIDTH             = 4,
  parameter int CYCLES_PER_SECOND = 125_000_000,
  parameter int HOLD_CYCLES       = CYCLES_PER_SECOND / 2,
  parameter int REPEAT_CYCLES     = CYCLES_PER_SECOND / 8,
  parameter bit WRAP              = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [3:0]       buttons,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             limit
);

  // One timer width serves both timers: it must hold the largest terminal value.
  localparam int MAX_HR = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int MAX_T  = (MAX_HR > CYCLES_PER_SECOND) ? MAX_HR : CYCLES_PER_SECOND;
  localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TW-1:0]    HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0]    TICK_LAST   = TW'(CYCLES_PER_SECOND - 1);
  localparam logic [WIDTH-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             dir_up_reg, dir_up_next;      // 1 = UP, 0 = DN
  logic [TW-1:0]    rep_timer_reg, rep_timer_next;
  logic [TW-1:0]    tick_timer_reg, tick_timer_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             running_reg, running_next;
  logic             limit_reg, limit_next;
  logic [3:0]       btn_prev_reg;

  logic [3:0]       rise;
  logic             dir_btn;
  logic             step_req;
  logic             step_up;

  // State register. Every register, including the previous-button copy,
  // advances only on ce=1 cycles. A rising edge that arrives while ce=0
  // is therefore still seen on the first enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      dir_up_reg     <= 1'b1;
      rep_timer_reg  <= '0;
      tick_timer_reg <= '0;
      count_reg      <= '0;
      running_reg    <= 1'b0;
      limit_reg      <= 1'b0;
      btn_prev_reg   <= '0;
    end else if (ce) begin
      state_reg      <= state_next;
      dir_up_reg     <= dir_up_next;
      rep_timer_reg  <= rep_timer_next;
      tick_timer_reg <= tick_timer_next;
      count_reg      <= count_next;
      running_reg    <= running_next;
      limit_reg      <= limit_next;
      btn_prev_reg   <= buttons;
    end
  end

  // Next-state logic. The priority order is clear, then the FSM step, then
  // the run tick. Later assignments in this block override earlier ones.
  always_comb begin
    state_next      = state_reg;
    dir_up_next     = dir_up_reg;
    rep_timer_next  = rep_timer_reg;
    tick_timer_next = tick_timer_reg;
    count_next      = count_reg;
    running_next    = running_reg;
    limit_next      = 1'b0;
    step_req        = 1'b0;
    step_up         = 1'b1;

    rise    = buttons & ~btn_prev_reg;
    dir_btn = dir_up_reg ? buttons[0] : buttons[1];

    // Auto-repeat FSM. Edges of the opposite button arriving outside IDLE
    // are simply dropped, because the previous-button register moves on.
    case (state_reg)
      ST_IDLE: begin
        if (rise[0]) begin
          step_req       = 1'b1;
          step_up        = 1'b1;
          dir_up_next    = 1'b1;
          state_next     = ST_DELAY;
          rep_timer_next = '0;
        end else if (rise[1]) begin
          step_req       = 1'b1;
          step_up        = 1'b0;
          dir_up_next    = 1'b0;
          state_next     = ST_DELAY;
          rep_timer_next = '0;
        end
      end
      ST_DELAY: begin
        if (!dir_btn) begin
          state_next     = ST_IDLE;
          rep_timer_next = '0;
        end else if (rep_timer_reg == HOLD_LAST) begin
          step_req       = 1'b1;
          step_up        = dir_up_reg;
          rep_timer_next = '0;
          state_next     = ST_REPEAT;
        end else begin
          rep_timer_next = rep_timer_reg + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!dir_btn) begin
          state_next     = ST_IDLE;
          rep_timer_next = '0;
        end else if (rep_timer_reg == REPEAT_LAST) begin
          step_req       = 1'b1;
          step_up        = dir_up_reg;
          rep_timer_next = '0;
        end else begin
          rep_timer_next = rep_timer_reg + 1'b1;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        rep_timer_next = '0;
      end
    endcase

    // Run tick. It advances only while the FSM sits in IDLE and stays there,
    // so a press restarts the second from zero and never collides with it.
    if (running_reg && (state_reg == ST_IDLE) && (state_next == ST_IDLE)) begin
      if (tick_timer_reg == TICK_LAST) begin
        tick_timer_next = '0;
        step_req        = 1'b1;
        step_up         = 1'b1;
      end else begin
        tick_timer_next = tick_timer_reg + 1'b1;
      end
    end else begin
      tick_timer_next = '0;
    end

    // Step arithmetic. A blocked or wrapped step raises limit.
    if (step_req) begin
      if (step_up) begin
        if (count_reg == CNT_MAX) begin
          limit_next = 1'b1;
          count_next = WRAP ? '0 : count_reg;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end else begin
        if (count_reg == '0) begin
          limit_next = 1'b1;
          count_next = WRAP ? CNT_MAX : count_reg;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
    end

    // Clear acts on level (which covers the edge) and overrides any step.
    if (buttons[3]) begin
      count_next      = '0;
      state_next      = ST_IDLE;
      rep_timer_next  = '0;
      tick_timer_next = '0;
      limit_next      = 1'b0;
    end

    // Run toggle is independent of clear.
    if (rise[2]) begin
      running_next    = ~running_reg;
      tick_timer_next = '0;
    end
  end

  // Outputs are driven directly from registers.
  always_comb begin
    count   = count_reg;
    running = running_reg;
    limit   = limit_reg;
  end

endmodule

// File: tb/tb_updown_counter_repeat.sv
// tb_updown_counter_repeat
//   Scoreboard bench. The driver applies inputs on the falling edge and
//   queues the outputs the counter must show after the next rising edge.
//   The monitor pops each entry one unit after that rising edge and compares.
//   Instance a uses wrap arithmetic. Instance b uses saturating arithmetic.
module tb_updown_counter_repeat;

  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int CPS  = 8;

  logic       clk;
  logic       rst_a, ce_a, rst_b, ce_b;
  logic [3:0] btn_a, btn_b;
  logic [3:0] count_a, count_b;
  logic       running_a, running_b, limit_a, limit_b;

  typedef struct {
    bit         sel;
    logic [3:0] cnt;
    logic       lim;
    logic       run;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  logic [3:0] exp_cnt [2];
  logic       exp_run [2];
  int n_checks = 0;
  int n_errors = 0;

  updown_counter_repeat #(
    .WIDTH(4), .CYCLES_PER_SECOND(CPS), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .WRAP(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .buttons(btn_a),
    .count(count_a), .running(running_a), .limit(limit_a)
  );

  updown_counter_repeat #(
    .WIDTH(4), .CYCLES_PER_SECOND(CPS), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .WRAP(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .buttons(btn_b),
    .count(count_b), .running(running_b), .limit(limit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: pops one expectation per clock, just after the rising edge.
  exp_t  mon_e;
  string mon_t;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      if (!mon_e.sel) begin
        check({mon_t, ".count"},   32'(count_a),   32'(mon_e.cnt));
        check({mon_t, ".limit"},   32'(limit_a),   32'(mon_e.lim));
        check({mon_t, ".running"}, 32'(running_a), 32'(mon_e.run));
        $display("txn %s dut_a count=%0d limit=%0d running=%0d", mon_t, count_a, limit_a, running_a);
      end else begin
        check({mon_t, ".count"},   32'(count_b),   32'(mon_e.cnt));
        check({mon_t, ".limit"},   32'(limit_b),   32'(mon_e.lim));
        check({mon_t, ".running"}, 32'(running_b), 32'(mon_e.run));
        $display("txn %s dut_b count=%0d limit=%0d running=%0d", mon_t, count_b, limit_b, running_b);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic drv(input bit s, input logic r, input logic c, input logic [3:0] b,
                     input logic lim, input string tag);
    @(negedge clk);
    if (!s) begin
      rst_a = r; ce_a = c; btn_a = b;
    end else begin
      rst_b = r; ce_b = c; btn_b = b;
    end
    exp_q.push_back('{sel: s, cnt: exp_cnt[s], lim: lim, run: exp_run[s]});
    tag_q.push_back(tag);
  endtask

  // Reference step: move the expected count and report whether limit pulses.
  task automatic do_step(input bit s, input bit up, input bit wrap, output logic l);
    l = 1'b0;
    if (up) begin
      if (exp_cnt[s] == 4'hF) begin
        l = 1'b1;
        if (wrap) exp_cnt[s] = 4'h0;
      end else begin
        exp_cnt[s] = exp_cnt[s] + 4'h1;
      end
    end else begin
      if (exp_cnt[s] == 4'h0) begin
        l = 1'b1;
        if (wrap) exp_cnt[s] = 4'hF;
      end else begin
        exp_cnt[s] = exp_cnt[s] - 4'h1;
      end
    end
  endtask

  // Hold a button pattern for n cycles. The first cycle is the press step.
  // Repeats come HOLD cycles later, then every REP cycles.
  task automatic hold(input bit s, input logic [3:0] b, input int n, input bit up,
                      input bit wrap, input string tag);
    for (int k = 0; k < n; k++) begin
      logic l;
      l = 1'b0;
      if (k == 0 || (k >= HOLD && ((k - HOLD) % REP) == 0)) do_step(s, up, wrap, l);
      drv(s, 1'b0, 1'b1, b, l, tag);
    end
  endtask

  // Idle cycles in run mode. Tick steps land every CPS cycles after the tick timer restarts.
  task automatic run_idle(input int n, input string tag);
    for (int j = 1; j <= n; j++) begin
      logic l;
      l = 1'b0;
      if ((j % CPS) == 0) do_step(1'b0, 1'b1, 1'b1, l);
      drv(1'b0, 1'b0, 1'b1, 4'b0000, l, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic l;
    rst_a = 1'b1; ce_a = 1'b1; btn_a = 4'b0000;
    rst_b = 1'b1; ce_b = 1'b1; btn_b = 4'b0000;
    exp_cnt[0] = 4'h0; exp_cnt[1] = 4'h0;
    exp_run[0] = 1'b0; exp_run[1] = 1'b0;

    // Reset state of both instances
    drv(0, 1'b1, 1'b1, 4'b0000, 1'b0, "reset_a");
    drv(1, 1'b1, 1'b1, 4'b0000, 1'b0, "reset_b");
    drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "idle_a");
    drv(1, 1'b0, 1'b1, 4'b0000, 1'b0, "idle_b");

    // Saturating instance: dec at 0, hold inc into the top, inc at max
    do_step(1, 1'b0, 1'b0, l);
    drv(1, 1'b0, 1'b1, 4'b0010, l, "b_dec_at_zero");
    drv(1, 1'b0, 1'b1, 4'b0000, 1'b0, "b_release");
    hold(1, 4'b0001, 40, 1'b1, 1'b0, "b_hold_inc_sat");
    drv(1, 1'b0, 1'b1, 4'b0000, 1'b0, "b_release");
    do_step(1, 1'b1, 1'b0, l);
    drv(1, 1'b0, 1'b1, 4'b0001, l, "b_inc_at_max");
    drv(1, 1'b0, 1'b1, 4'b0000, 1'b0, "b_release");
    do_step(1, 1'b0, 1'b0, l);
    drv(1, 1'b0, 1'b1, 4'b0010, l, "b_dec_from_max");
    drv(1, 1'b0, 1'b1, 4'b0000, 1'b0, "b_release");

    // Three single-cycle taps with gaps
    for (int i = 0; i < 3; i++) begin
      do_step(0, 1'b1, 1'b1, l);
      drv(0, 1'b0, 1'b1, 4'b0001, l, "a_tap_inc");
      drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_gap");
      drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_gap");
    end

    // Clear, then a 12-cycle hold from zero
    exp_cnt[0] = 4'h0;
    drv(0, 1'b0, 1'b1, 4'b1000, 1'b0, "a_clear");
    drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_idle");
    hold(0, 4'b0001, 12, 1'b1, 1'b1, "a_hold_inc");
    drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_release");

    // Wrap both ways
    exp_cnt[0] = 4'h0;
    drv(0, 1'b0, 1'b1, 4'b1000, 1'b0, "a_clear");
    do_step(0, 1'b0, 1'b1, l);
    drv(0, 1'b0, 1'b1, 4'b0010, l, "a_dec_wrap");
    drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_release");
    do_step(0, 1'b1, 1'b1, l);
    drv(0, 1'b0, 1'b1, 4'b0001, l, "a_inc_wrap");
    drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_release");

    // Run mode, hold suppresses the tick, then run off
    exp_run[0] = 1'b1;
    drv(0, 1'b0, 1'b1, 4'b0100, 1'b0, "a_run_on");
    run_idle(20, "a_run_tick");
    hold(0, 4'b0001, 6, 1'b1, 1'b1, "a_hold_while_run");
    drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_release_run");
    run_idle(10, "a_run_tick2");
    exp_run[0] = 1'b0;
    drv(0, 1'b0, 1'b1, 4'b0100, 1'b0, "a_run_off");
    for (int i = 0; i < 10; i++) drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_frozen");

    // Both directions together, then clear while held and running
    exp_run[0] = 1'b1;
    drv(0, 1'b0, 1'b1, 4'b0100, 1'b0, "a_run_on2");
    hold(0, 4'b0011, 8, 1'b1, 1'b1, "a_both_hold");
    exp_cnt[0] = 4'h0;
    drv(0, 1'b0, 1'b1, 4'b1011, 1'b0, "a_clear_hold");
    drv(0, 1'b0, 1'b1, 4'b1011, 1'b0, "a_clear_hold");
    run_idle(3, "a_after_clear");
    exp_run[0] = 1'b0;
    drv(0, 1'b0, 1'b1, 4'b0100, 1'b0, "a_run_off2");
    do_step(0, 1'b1, 1'b1, l);
    drv(0, 1'b0, 1'b1, 4'b0001, l, "a_idle_after_clear");
    drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_release");

    // Clock enable low during the press, then reset mid-repeat
    exp_run[0] = 1'b1;
    drv(0, 1'b0, 1'b1, 4'b0100, 1'b0, "a_run_on3");
    for (int i = 0; i < 3; i++) drv(0, 1'b0, 1'b0, 4'b0001, 1'b0, "a_ce_low");
    hold(0, 4'b0001, 6, 1'b1, 1'b1, "a_ce_high_hold");
    exp_cnt[0] = 4'h0;
    exp_run[0] = 1'b0;
    drv(0, 1'b1, 1'b1, 4'b0001, 1'b0, "a_rst_mid_repeat");
    drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_after_rst");
    drv(0, 1'b0, 1'b1, 4'b0000, 1'b0, "a_after_rst");

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
